// File: rtl/uart_prog_loader_pkg.sv
// Shared constants and state encodings for the UART program loader.
package uart_prog_loader_pkg;

  // First byte of every program frame.
  localparam logic [7:0] HDR_BYTE = 8'hA5;

  // Short bit period for simulation.
  localparam int CLKS_PER_BIT_SIM = 4;

  // Loader frame-parsing states.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN,
    ST_DATA,
    ST_WRITE,
    ST_CSUM,
    ST_DONE,
    ST_ERR
  } loader_state_t;

  // UART receive bit-sampler states.
  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 UART receiver: 2-FF synchronizer plus a mid-bit sampler.
// It emits a one-cycle byte_valid on a good stop bit, or a one-cycle
// frame_error on a bad stop bit.
module uart_rx_byte
  import uart_prog_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       frame_error
);

  localparam int CW   = $clog2(CLKS_PER_BIT);
  localparam int HALF = CLKS_PER_BIT / 2;

  logic          rx_meta, rx_s, rx_prev;
  rx_state_t     state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0]    bit_idx, bit_idx_n;
  logic [7:0]    shreg, shreg_n;
  logic [7:0]    byte_data_n;
  logic          byte_valid_n, frame_error_n;

  // Synchronize rx and keep its previous value for falling-edge detection.
  // NOTE: these flops reset to 1, the idle line level, so that releasing
  // reset never looks like a start-bit edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
      rx_prev <= rx_s;
    end
  end

  // Sampler state register and registered outputs.
  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge value regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= RX_IDLE;
      cnt         <= '0;
      bit_idx     <= '0;
      shreg       <= '0;
      byte_data   <= '0;
      byte_valid  <= 1'b0;
      frame_error <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      bit_idx     <= bit_idx_n;
      shreg       <= shreg_n;
      byte_data   <= byte_data_n;
      byte_valid  <= byte_valid_n;
      frame_error <= frame_error_n;
    end
  end

  // Next-state logic: confirm start at half bit, then sample once per bit.
  // NOTE: every output of this block gets a default first, so no path can
  // leave a value unassigned and infer a latch.
  always_comb begin
    state_n       = state;
    cnt_n         = cnt;
    bit_idx_n     = bit_idx;
    shreg_n       = shreg;
    byte_data_n   = byte_data;
    byte_valid_n  = 1'b0;
    frame_error_n = 1'b0;
    case (state)
      RX_IDLE: begin
        if (rx_prev && !rx_s) begin
          state_n = RX_START;
          cnt_n   = '0;
        end
      end
      RX_START: begin
        if (cnt == CW'(HALF - 1)) begin
          cnt_n     = '0;
          bit_idx_n = '0;
          state_n   = rx_s ? RX_IDLE : RX_DATA;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      RX_DATA: begin
        if (cnt == CW'(CLKS_PER_BIT - 1)) begin
          cnt_n     = '0;
          shreg_n   = {rx_s, shreg[7:1]};
          bit_idx_n = bit_idx + 3'd1;
          if (bit_idx == 3'd7) state_n = RX_STOP;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      RX_STOP: begin
        if (cnt == CW'(CLKS_PER_BIT - 1)) begin
          cnt_n   = '0;
          state_n = RX_IDLE;
          if (rx_s) begin
            byte_valid_n = 1'b1;
            byte_data_n  = shreg;
          end else begin
            frame_error_n = 1'b1;
          end
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      default: state_n = RX_IDLE;
    endcase
  end

endmodule

// File: rtl/uart_prog_loader.sv
// Receives a framed program image over UART and writes it word by word
// into instruction/data memory while holding the core in reset.
module uart_prog_loader
  import uart_prog_loader_pkg::*;
#(
  parameter int          CLKS_PER_BIT = 868,
  parameter int          TIMEOUT_CLKS = 10_000_000,
  parameter logic [31:0] BASE_ADDR    = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx,
  input  logic        load_en,
  output logic        mem_we,
  output logic [31:0] mem_a,
  output logic [31:0] mem_wd,
  output logic        cpu_reset,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [7:0]  word_cnt
);

  localparam int TW = $clog2(TIMEOUT_CLKS + 1);

  logic          byte_valid, frame_error;
  logic [7:0]    byte_data;
  loader_state_t state, state_n;
  logic [7:0]    len, len_n, word_cnt_n, csum, csum_n;
  logic [1:0]    lane, lane_n;
  logic [31:0]   wbuf, wbuf_n, mem_a_n, mem_wd_n;
  logic [TW-1:0] tmo_cnt, tmo_cnt_n;
  logic          done_n, err_n, timeout;

  uart_rx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk         (clk),
    .reset       (reset),
    .rx          (rx),
    .byte_valid  (byte_valid),
    .byte_data   (byte_data),
    .frame_error (frame_error)
  );

  assign busy      = state inside {ST_LEN, ST_DATA, ST_WRITE, ST_CSUM};
  assign mem_we    = (state == ST_WRITE) && load_en;
  assign cpu_reset = reset | load_en;
  assign timeout   = busy && (tmo_cnt == TW'(TIMEOUT_CLKS - 1));

  // Loader state register, frame datapath and memory-port registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      len      <= '0;
      word_cnt <= '0;
      csum     <= '0;
      lane     <= '0;
      wbuf     <= '0;
      tmo_cnt  <= '0;
      mem_a    <= BASE_ADDR;
      mem_wd   <= '0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      state    <= state_n;
      len      <= len_n;
      word_cnt <= word_cnt_n;
      csum     <= csum_n;
      lane     <= lane_n;
      wbuf     <= wbuf_n;
      tmo_cnt  <= tmo_cnt_n;
      mem_a    <= mem_a_n;
      mem_wd   <= mem_wd_n;
      done     <= done_n;
      err      <= err_n;
    end
  end

  // Frame parser; aborts are applied last so they override the byte action.
  always_comb begin
    state_n    = state;
    len_n      = len;
    word_cnt_n = word_cnt;
    csum_n     = csum;
    lane_n     = lane;
    wbuf_n     = wbuf;
    mem_a_n    = mem_a;
    mem_wd_n   = mem_wd;
    done_n     = done;
    err_n      = err;
    tmo_cnt_n  = busy ? tmo_cnt + TW'(1) : '0;
    if (byte_valid) tmo_cnt_n = '0;

    case (state)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (byte_valid && load_en && byte_data == HDR_BYTE) begin
          state_n    = ST_LEN;
          done_n     = 1'b0;
          err_n      = 1'b0;
          word_cnt_n = '0;
          csum_n     = '0;
          lane_n     = '0;
        end
      end
      ST_LEN: begin
        if (byte_valid) begin
          if (byte_data == 8'd0) begin
            state_n = ST_ERR;
            err_n   = 1'b1;
          end else begin
            len_n   = byte_data;
            state_n = ST_DATA;
          end
        end
      end
      ST_DATA: begin
        if (byte_valid) begin
          // Little-endian: bytes shift in from the top, first byte ends at [7:0].
          wbuf_n = {byte_data, wbuf[31:8]};
          csum_n = csum ^ byte_data;
          lane_n = lane + 2'd1;
          if (lane == 2'd3) begin
            mem_wd_n = {byte_data, wbuf[31:8]};
            mem_a_n  = BASE_ADDR + {22'd0, word_cnt, 2'b00};
            state_n  = ST_WRITE;
          end
        end
      end
      ST_WRITE: begin
        word_cnt_n = word_cnt + 8'd1;
        state_n    = (word_cnt + 8'd1 == len) ? ST_CSUM : ST_DATA;
      end
      ST_CSUM: begin
        if (byte_valid) begin
          if (byte_data == csum) begin
            state_n = ST_DONE;
            done_n  = 1'b1;
          end else begin
            state_n = ST_ERR;
            err_n   = 1'b1;
          end
        end
      end
      default: state_n = ST_IDLE;
    endcase

    // The byte wins over a same-cycle timeout; a dropped load_en wins over all.
    if (busy && ((timeout && !byte_valid) || frame_error || !load_en)) begin
      state_n    = ST_ERR;
      err_n      = 1'b1;
      done_n     = 1'b0;
      word_cnt_n = word_cnt;
      mem_a_n    = mem_a;
      mem_wd_n   = mem_wd;
    end
  end

endmodule

// File: tb/tb_uart_prog_loader.sv
// Directed bench for uart_prog_loader with a short bit period and timeout.
module tb_uart_prog_loader;
  import uart_prog_loader_pkg::*;

  localparam int CPB = CLKS_PER_BIT_SIM;

  logic        clk = 1'b0;
  logic        reset, rx, load_en;
  logic        mem_we, cpu_reset, busy, done, err;
  logic [31:0] mem_a, mem_wd;
  logic [7:0]  word_cnt;

  int vec_cnt  = 0;
  int miss_cnt = 0;
  int w0;

  logic [31:0] wr_a[$];
  logic [31:0] wr_d[$];

  uart_prog_loader #(
    .CLKS_PER_BIT (CPB),
    .TIMEOUT_CLKS (200),
    .BASE_ADDR    (32'h0000_0000)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .rx        (rx),
    .load_en   (load_en),
    .mem_we    (mem_we),
    .mem_a     (mem_a),
    .mem_wd    (mem_wd),
    .cpu_reset (cpu_reset),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .word_cnt  (word_cnt)
  );

  always #5 clk = ~clk;

  // Log every write strobe, sampled away from the active edge.
  always @(negedge clk) begin
    if (mem_we) begin
      wr_a.push_back(mem_a);
      wr_d.push_back(mem_wd);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      miss_cnt++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_write(input string tag, input int idx, input logic [31:0] a,
                             input logic [31:0] d);
    if (idx < wr_a.size()) begin
      check({tag, "_addr"}, wr_a[idx], a);
      check({tag, "_data"}, wr_d[idx], d);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic v);
    rx = v;
    idle(CPB);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop = 1'b1);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(stop);
    rx = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; rx = 1'b1; load_en = 1'b0;
    idle(3);
    check("rst_we", mem_we, 0);
    check("rst_a", mem_a, 32'h0);
    check("rst_wd", mem_wd, 32'h0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_wcnt", word_cnt, 0);
    check("rst_cpurst", cpu_reset, 1);
    reset = 1'b0;
    idle(5);
    check("idle_cpurst", cpu_reset, 0);

    // Good two-word load; XOR of the eight data bytes is 0x2A.
    load_en = 1'b1;
    idle(2);
    check("load_cpurst", cpu_reset, 1);
    w0 = wr_a.size();
    send_byte(8'hA5); send_byte(8'h02);
    send_byte(8'h78); send_byte(8'h56); send_byte(8'h34); send_byte(8'h12);
    send_byte(8'hEF); send_byte(8'hBE); send_byte(8'hAD); send_byte(8'hDE);
    send_byte(8'h2A);
    idle(10);
    check("good_nwr", wr_a.size() - w0, 2);
    check_write("good_w0", w0, 32'h0, 32'h1234_5678);
    check_write("good_w1", w0 + 1, 32'h4, 32'hDEAD_BEEF);
    check("good_done", done, 1);
    check("good_err", err, 0);
    check("good_wcnt", word_cnt, 2);
    check("good_busy", busy, 0);
    check("good_a_hold", mem_a, 32'h4);
    check("good_wd_hold", mem_wd, 32'hDEAD_BEEF);

    // Same frame, wrong checksum: writes still happen, then err.
    w0 = wr_a.size();
    send_byte(8'hA5); send_byte(8'h02);
    send_byte(8'h78); send_byte(8'h56); send_byte(8'h34); send_byte(8'h12);
    send_byte(8'hEF); send_byte(8'hBE); send_byte(8'hAD); send_byte(8'hDE);
    send_byte(8'h22);
    idle(10);
    check("bad_nwr", wr_a.size() - w0, 2);
    check_write("bad_w1", w0 + 1, 32'h4, 32'hDEAD_BEEF);
    check("bad_err", err, 1);
    check("bad_done", done, 0);

    // Zero length is rejected.
    send_byte(8'hA5); send_byte(8'h00);
    idle(10);
    check("len0_err", err, 1);
    check("len0_busy", busy, 0);

    // Framing error in DATA.
    w0 = wr_a.size();
    send_byte(8'hA5); send_byte(8'h01);
    check("fe_busy_before", busy, 1);
    send_byte(8'h55, 1'b0);
    idle(10);
    check("fe_err", err, 1);
    check("fe_done", done, 0);
    check("fe_nwr", wr_a.size() - w0, 0);

    // A full frame with load_en low is ignored.
    load_en = 1'b0;
    w0 = wr_a.size();
    send_byte(8'hA5); send_byte(8'h01);
    send_byte(8'h04); send_byte(8'h03); send_byte(8'h02); send_byte(8'h01);
    send_byte(8'h04);
    idle(10);
    check("gate_nwr", wr_a.size() - w0, 0);
    check("gate_done", done, 0);
    check("gate_wcnt", word_cnt, 0);
    load_en = 1'b1;

    // A one-clock glitch between LEN and data must not shift the lanes.
    w0 = wr_a.size();
    send_byte(8'hA5); send_byte(8'h01);
    rx = 1'b0; idle(1); rx = 1'b1; idle(20);
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
    send_byte(8'h04);
    idle(10);
    check("glitch_nwr", wr_a.size() - w0, 1);
    check_write("glitch_w0", w0, 32'h0, 32'h0403_0201);
    check("glitch_done", done, 1);

    // Timeout mid-frame.
    w0 = wr_a.size();
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h11); send_byte(8'h22);
    idle(2);
    check("tmo_busy", busy, 1);
    check("tmo_err_before", err, 0);
    idle(250);
    check("tmo_err", err, 1);
    check("tmo_busy_after", busy, 0);
    check("tmo_nwr", wr_a.size() - w0, 0);

    // load_en dropped mid-frame aborts at the next clock.
    w0 = wr_a.size();
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h11); send_byte(8'h22);
    idle(2);
    check("abort_busy", busy, 1);
    load_en = 1'b0;
    idle(1);
    check("abort_err", err, 1);
    check("abort_busy_after", busy, 0);
    check("abort_cpurst", cpu_reset, 0);
    send_byte(8'h33); send_byte(8'h44);
    idle(10);
    check("abort_nwr", wr_a.size() - w0, 0);
    load_en = 1'b1;

    // Async reset in DATA after one word, then a clean one-word frame.
    w0 = wr_a.size();
    send_byte(8'hA5); send_byte(8'h02);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
    send_byte(8'h55);
    idle(3);
    check("pre_rst_wcnt", word_cnt, 1);
    reset = 1'b1;
    #1;
    check("arst_we", mem_we, 0);
    check("arst_a", mem_a, 32'h0);
    check("arst_wd", mem_wd, 32'h0);
    check("arst_busy", busy, 0);
    check("arst_done", done, 0);
    check("arst_err", err, 0);
    check("arst_wcnt", word_cnt, 0);
    idle(2);
    reset = 1'b0;
    idle(5);
    send_byte(8'hA5); send_byte(8'h01);
    send_byte(8'h04); send_byte(8'h03); send_byte(8'h02); send_byte(8'h01);
    send_byte(8'h04);
    idle(10);
    check("post_nwr", wr_a.size() - w0, 2);
    check_write("post_w0", w0, 32'h0, 32'h4433_2211);
    check_write("post_w1", w0 + 1, 32'h0, 32'h0102_0304);
    check("post_done", done, 1);
    check("post_err", err, 0);
    check("post_wcnt", word_cnt, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule
